// File: rtl/mc_sequencer.sv
// mc_sequencer: multi-cycle RISC-V control sequencer.
// Splits each instruction into FETCH/DECODE/EXECUTE/MEM/WB. Handshakes with
// variable-latency instruction and data memories. Includes a bus-timeout
// watchdog and a retired-instruction counter.
// Optional build macro MC_PERF_CNT_EN adds the cycle and stall counters
// (cyc_cnt, stall_cnt). Without it, both outputs are tied to zero.
module mc_sequencer #(
  parameter int CNT_W = 32,
  parameter int TMO_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [6:0]       opcode,
  input  logic             imem_ack,
  input  logic             dmem_ack,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             ir_we,
  output logic             pc_we,
  output logic             mem_read,
  output logic             mem_write,
  output logic             reg_write,
  output logic             alu_src,
  output logic             mem_2_reg,
  output logic [1:0]       alu_op,
  output logic             branch,
  output logic             jump,
  output logic             retire,
  output logic             busy,
  output logic             err,
  output logic [CNT_W-1:0] instret,
  output logic [CNT_W-1:0] cyc_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  // A request cycle with no ack while the counter holds this value is the
  // final tolerated cycle. With no ack, the watchdog reaches 2^TMO_W-1.
  localparam logic [TMO_W-1:0] TMO_LAST = {TMO_W{1'b1}} - TMO_W'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_ERR
  } state_t;

  typedef enum logic [2:0] {
    C_R, C_I, C_LD, C_ST, C_BR, C_JAL
  } cls_t;

  state_t           state, state_nx;
  cls_t             cls, op_cls;
  logic             op_legal;
  logic [TMO_W-1:0] tmo_cnt;
  logic             stall;
  logic             tmo_hit;
  state_t           boundary;

  // Classify the raw opcode. The result is only captured in DECODE.
  always_comb begin
    op_cls   = C_R;
    op_legal = 1'b1;
    case (opcode)
      OP_R:    op_cls = C_R;
      OP_I:    op_cls = C_I;
      OP_LD:   op_cls = C_LD;
      OP_ST:   op_cls = C_ST;
      OP_BR:   op_cls = C_BR;
      OP_JAL:  op_cls = C_JAL;
      default: op_legal = 1'b0;
    endcase
  end

  assign stall    = (imem_req && !imem_ack) || (dmem_req && !dmem_ack);
  assign tmo_hit  = (tmo_cnt == TMO_LAST);
  assign boundary = enable ? S_FETCH : S_IDLE;
  assign busy     = (state != S_IDLE) && (state != S_ERR);
  assign err      = (state == S_ERR);

  // Next-state and control-strobe decode from state, latched class and acks.
  always_comb begin
    state_nx  = state;
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    reg_write = 1'b0;
    alu_src   = 1'b0;
    mem_2_reg = 1'b0;
    alu_op    = 2'b00;
    branch    = 1'b0;
    jump      = 1'b0;
    retire    = 1'b0;
    case (state)
      S_IDLE: if (enable) state_nx = S_FETCH;
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_we    = 1'b1;
          state_nx = S_DECODE;
        end else if (tmo_hit) begin
          state_nx = S_ERR;
        end
      end
      S_DECODE: state_nx = op_legal ? S_EXEC : S_ERR;
      S_EXEC: begin
        case (cls)
          C_R: begin
            alu_op   = 2'b10;
            state_nx = S_WB;
          end
          C_I: begin
            alu_op   = 2'b11;
            alu_src  = 1'b1;
            state_nx = S_WB;
          end
          C_LD, C_ST: begin
            alu_src  = 1'b1;
            state_nx = S_MEM;
          end
          C_BR: begin
            alu_op   = 2'b01;
            branch   = 1'b1;
            pc_we    = 1'b1;
            retire   = 1'b1;
            state_nx = boundary;
          end
          C_JAL: begin
            jump     = 1'b1;
            state_nx = S_WB;
          end
          default: state_nx = S_ERR;
        endcase
      end
      S_MEM: begin
        dmem_req  = 1'b1;
        alu_src   = 1'b1;
        mem_read  = (cls == C_LD);
        mem_write = (cls == C_ST);
        if (dmem_ack) begin
          if (cls == C_LD) begin
            state_nx = S_WB;
          end else begin
            pc_we    = 1'b1;
            retire   = 1'b1;
            state_nx = boundary;
          end
        end else if (tmo_hit) begin
          state_nx = S_ERR;
        end
      end
      S_WB: begin
        reg_write = 1'b1;
        pc_we     = 1'b1;
        retire    = 1'b1;
        mem_2_reg = (cls == C_LD);
        jump      = (cls == C_JAL);
        state_nx  = boundary;
      end
      S_ERR:   state_nx = S_ERR;
      default: state_nx = S_IDLE;
    endcase
  end

  // State register and opcode-class latch (class captured in DECODE only).
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cls   <= C_R;
    end else begin
      state <= state_nx;
      if (state == S_DECODE) cls <= op_cls;
    end
  end

  // Watchdog counts consecutive unacked request cycles. It restarts whenever a
  // request is acked or no request is pending, so each FETCH/MEM entry starts
  // from zero.
  always_ff @(posedge clk) begin
    if (rst)        tmo_cnt <= '0;
    else if (stall) tmo_cnt <= tmo_cnt + TMO_W'(1);
    else            tmo_cnt <= '0;
  end

  // Retired-instruction counter. It wraps naturally at 2^CNT_W.
  always_ff @(posedge clk) begin
    if (rst)         instret <= '0;
    else if (retire) instret <= instret + CNT_W'(1);
  end

`ifdef MC_PERF_CNT_EN
  logic [CNT_W-1:0] cyc_q, stall_q;

  // Performance counters: busy cycles and unacked request cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_q   <= '0;
      stall_q <= '0;
    end else begin
      if (busy)  cyc_q   <= cyc_q + CNT_W'(1);
      if (stall) stall_q <= stall_q + CNT_W'(1);
    end
  end

  assign cyc_cnt   = cyc_q;
  assign stall_cnt = stall_q;
`else
  assign cyc_cnt   = '0;
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_mc_sequencer.sv
// tb_mc_sequencer: randomized self-checking bench for mc_sequencer.
// Each instruction is expanded into an expected per-cycle trace of inputs
// and control outputs, built from the phase rules. The trace is played
// open-loop, with random values on inputs that must be ignored.
module tb_mc_sequencer;
  localparam int CW = 4;
  localparam int TW = 3;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [15:0] IREQ  = 16'h8000, DREQ = 16'h4000, IRWE = 16'h2000;
  localparam logic [15:0] PCWE  = 16'h1000, MRD  = 16'h0800, MWR  = 16'h0400;
  localparam logic [15:0] RW    = 16'h0200, ASRC = 16'h0100, M2R  = 16'h0080;
  localparam logic [15:0] AOP_B = 16'h0020, AOP_R = 16'h0040, AOP_I = 16'h0060;
  localparam logic [15:0] BRN   = 16'h0010, JMP  = 16'h0008, RET  = 16'h0004;
  localparam logic [15:0] BUSY  = 16'h0002, ERRB = 16'h0001;

  logic clk = 1'b0;
  logic rst, enable, imem_ack, dmem_ack;
  logic [6:0] opcode;
  logic imem_req, dmem_req, ir_we, pc_we, mem_read, mem_write, reg_write;
  logic alu_src, mem_2_reg, branch, jump, retire, busy, err;
  logic [1:0] alu_op;
  logic [CW-1:0] instret, cyc_cnt, stall_cnt;

  always #5 clk = ~clk;

  mc_sequencer #(.CNT_W(CW), .TMO_W(TW)) dut (
    .clk(clk), .rst(rst), .enable(enable), .opcode(opcode),
    .imem_ack(imem_ack), .dmem_ack(dmem_ack), .imem_req(imem_req),
    .dmem_req(dmem_req), .ir_we(ir_we), .pc_we(pc_we), .mem_read(mem_read),
    .mem_write(mem_write), .reg_write(reg_write), .alu_src(alu_src),
    .mem_2_reg(mem_2_reg), .alu_op(alu_op), .branch(branch), .jump(jump),
    .retire(retire), .busy(busy), .err(err), .instret(instret),
    .cyc_cnt(cyc_cnt), .stall_cnt(stall_cnt)
  );

  wire [15:0] obs = {imem_req, dmem_req, ir_we, pc_we, mem_read, mem_write,
                     reg_write, alu_src, mem_2_reg, alu_op, branch, jump,
                     retire, busy, err};

  typedef struct {
    logic       en, ia, da;
    logic [6:0] op;
    logic [15:0] exp;
  } ent_t;

  ent_t tq[$];
  ent_t done[$];
  logic [15:0]   o_out[$];
  logic [CW-1:0] o_ret[$], o_cyc[$], o_stl[$], e_ret[$], e_cyc[$], e_stl[$];
  logic [CW-1:0] m_ret, m_cyc, m_stl;
  int vecs = 0;
  int errs = 0;

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [6:0] rop();
    return 7'($urandom);
  endfunction

  task automatic push(input logic en, input logic ia, input logic da,
                      input logic [6:0] op, input logic [15:0] exp);
    ent_t e;
    e.en = en; e.ia = ia; e.da = da; e.op = op; e.exp = exp;
    tq.push_back(e);
  endtask

  // n idle cycles with enable low, then one with enable high (IDLE -> FETCH)
  task automatic add_idle(input int n);
    for (int i = 0; i < n; i++) push(1'b0, rb(), rb(), rop(), 16'h0);
    push(1'b1, rb(), rb(), rop(), 16'h0);
  endtask

  // Expected trace of one instruction: fd unacked fetch cycles, md unacked
  // memory cycles, and enable = en_after on its last (boundary) cycle.
  task automatic add_instr(input logic [6:0] opc, input int fd, input int md,
                           input logic en_after);
    logic [15:0] mx;
    for (int i = 0; i < fd; i++) push(rb(), 1'b0, rb(), rop(), IREQ | BUSY);
    push(rb(), 1'b1, rb(), rop(), IREQ | IRWE | BUSY);
    push(rb(), rb(), rb(), opc, BUSY);
    case (opc)
      OP_R: begin
        push(rb(), rb(), rb(), rop(), AOP_R | BUSY);
        push(en_after, rb(), rb(), rop(), RW | PCWE | RET | BUSY);
      end
      OP_I: begin
        push(rb(), rb(), rb(), rop(), AOP_I | ASRC | BUSY);
        push(en_after, rb(), rb(), rop(), RW | PCWE | RET | BUSY);
      end
      OP_LD, OP_ST: begin
        push(rb(), rb(), rb(), rop(), ASRC | BUSY);
        mx = DREQ | ASRC | BUSY | ((opc == OP_LD) ? MRD : MWR);
        for (int i = 0; i < md; i++) push(rb(), rb(), 1'b0, rop(), mx);
        if (opc == OP_LD) begin
          push(rb(), rb(), 1'b1, rop(), mx);
          push(en_after, rb(), rb(), rop(), RW | PCWE | RET | M2R | BUSY);
        end else begin
          push(en_after, rb(), 1'b1, rop(), mx | PCWE | RET);
        end
      end
      OP_BR:  push(en_after, rb(), rb(), rop(), AOP_B | BRN | PCWE | RET | BUSY);
      OP_JAL: begin
        push(rb(), rb(), rb(), rop(), JMP | BUSY);
        push(en_after, rb(), rb(), rop(), RW | PCWE | RET | JMP | BUSY);
      end
      default: ; // illegal: the trace ends at DECODE; the caller appends ERR
    endcase
  endtask

  // Apply queued cycles, record DUT outputs, and advance the counter model.
  task automatic run_trace();
    ent_t e;
    done.delete(); o_out.delete(); o_ret.delete(); o_cyc.delete(); o_stl.delete();
    e_ret.delete(); e_cyc.delete(); e_stl.delete();
    while (tq.size() > 0) begin
      e = tq.pop_front();
      enable = e.en; imem_ack = e.ia; dmem_ack = e.da; opcode = e.op;
      @(negedge clk);
      done.push_back(e);
      o_out.push_back(obs); o_ret.push_back(instret);
      o_cyc.push_back(cyc_cnt); o_stl.push_back(stall_cnt);
      e_ret.push_back(m_ret);
`ifdef MC_PERF_CNT_EN
      e_cyc.push_back(m_cyc); e_stl.push_back(m_stl);
`else
      e_cyc.push_back('0); e_stl.push_back('0);
`endif
      m_ret = m_ret + CW'(e.exp[2]);
      m_cyc = m_cyc + CW'(e.exp[1]);
      m_stl = m_stl + CW'((e.exp[15] && !e.ia) || (e.exp[14] && !e.da));
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; enable = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0; opcode = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    m_ret = '0; m_cyc = '0; m_stl = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0; opcode = '0;
    @(posedge clk); @(negedge clk);
    vecs++;
    if (obs !== 16'h0) begin errs++; $display("FAIL reset outputs got %h want 0000", obs); end
    if (instret !== '0) begin errs++; $display("FAIL reset instret got %0d want 0", instret); end
    if (cyc_cnt !== '0 || stall_cnt !== '0) begin
      errs++; $display("FAIL reset perf got %0d/%0d want 0/0", cyc_cnt, stall_cnt);
    end
    @(posedge clk); #1 rst = 1'b0;
    m_ret = '0; m_cyc = '0; m_stl = '0;
    @(negedge clk);
    if (obs !== 16'h0) begin errs++; $display("FAIL reset_idle outputs got %h want 0000", obs); end
    @(posedge clk); #1;
  endtask

  task automatic test_r_type();
    add_idle(0);
    add_instr(OP_R, 0, 0, 1'b0);
    run_trace();
    foreach (done[i]) begin
      vecs++;
      if (o_out[i] !== done[i].exp) begin errs++; $display("FAIL r_type c%0d outputs got %h want %h", i, o_out[i], done[i].exp); end
      if (o_ret[i] !== e_ret[i]) begin errs++; $display("FAIL r_type c%0d instret got %0d want %0d", i, o_ret[i], e_ret[i]); end
    end
    if (instret !== CW'(1)) begin errs++; $display("FAIL r_type final instret got %0d want 1", instret); end
  endtask

  task automatic test_ld_stall();
    logic [CW-1:0] want;
    do_reset();
    add_idle(0);
    add_instr(OP_LD, 0, 3, 1'b0);
    run_trace();
    foreach (done[i]) begin
      vecs++;
      if (o_out[i] !== done[i].exp) begin errs++; $display("FAIL ld_stall c%0d outputs got %h want %h", i, o_out[i], done[i].exp); end
      if (o_cyc[i] !== e_cyc[i] || o_stl[i] !== e_stl[i]) begin
        errs++; $display("FAIL ld_stall c%0d perf got %0d/%0d want %0d/%0d", i, o_cyc[i], o_stl[i], e_cyc[i], e_stl[i]);
      end
    end
`ifdef MC_PERF_CNT_EN
    want = CW'(3);
`else
    want = '0;
`endif
    if (stall_cnt !== want) begin errs++; $display("FAIL ld_stall stall_cnt got %0d want %0d", stall_cnt, want); end
  endtask

  task automatic test_st_br_jal();
    logic [CW-1:0] start;
    start = instret;
    add_idle(1);
    add_instr(OP_ST, 1, 2, 1'b1);
    add_instr(OP_BR, 0, 0, 1'b1);
    add_instr(OP_JAL, 2, 0, 1'b0);
    run_trace();
    foreach (done[i]) begin
      vecs++;
      if (o_out[i] !== done[i].exp) begin errs++; $display("FAIL st_br_jal c%0d outputs got %h want %h", i, o_out[i], done[i].exp); end
      if (o_ret[i] !== e_ret[i]) begin errs++; $display("FAIL st_br_jal c%0d instret got %0d want %0d", i, o_ret[i], e_ret[i]); end
    end
    if (instret !== CW'(start + CW'(3))) begin
      errs++; $display("FAIL st_br_jal instret got %0d want %0d", instret, CW'(start + CW'(3)));
    end
  endtask

  task automatic test_timeout();
    do_reset();
    add_idle(1);
    for (int i = 0; i < 7; i++) push(rb(), 1'b0, rb(), rop(), IREQ | BUSY);
    for (int i = 0; i < 3; i++) push(rb(), rb(), rb(), rop(), ERRB);
    run_trace();
    foreach (done[i]) begin
      vecs++;
      if (o_out[i] !== done[i].exp) begin errs++; $display("FAIL tmo_fetch c%0d outputs got %h want %h", i, o_out[i], done[i].exp); end
    end
    do_reset();
    @(negedge clk);
    vecs++;
    if (obs !== 16'h0) begin errs++; $display("FAIL tmo_clear outputs got %h want 0000", obs); end
    @(posedge clk); #1;
    add_idle(0);
    add_instr(OP_LD, 0, 7, 1'b0);
    void'(tq.pop_back()); void'(tq.pop_back());
    for (int i = 0; i < 3; i++) push(rb(), rb(), rb(), rop(), ERRB);
    run_trace();
    foreach (done[i]) begin
      vecs++;
      if (o_out[i] !== done[i].exp) begin errs++; $display("FAIL tmo_mem c%0d outputs got %h want %h", i, o_out[i], done[i].exp); end
    end
  endtask

  task automatic test_illegal_and_rst();
    do_reset();
    add_idle(0);
    add_instr(7'b1111111, 2, 0, 1'b0);
    for (int i = 0; i < 3; i++) push(rb(), rb(), rb(), rop(), ERRB);
    run_trace();
    foreach (done[i]) begin
      vecs++;
      if (o_out[i] !== done[i].exp) begin errs++; $display("FAIL illegal c%0d outputs got %h want %h", i, o_out[i], done[i].exp); end
    end
    do_reset();
    add_idle(0);
    add_instr(OP_LD, 0, 5, 1'b0);
    repeat (3) void'(tq.pop_back());
    run_trace();
    foreach (done[i]) begin
      vecs++;
      if (o_out[i] !== done[i].exp) begin errs++; $display("FAIL rst_mem c%0d outputs got %h want %h", i, o_out[i], done[i].exp); end
    end
    rst = 1'b1; dmem_ack = 1'b0; enable = 1'b1;
    @(posedge clk); @(negedge clk);
    vecs++;
    if (obs !== 16'h0) begin errs++; $display("FAIL rst_mem_after outputs got %h want 0000", obs); end
    if (instret !== '0) begin errs++; $display("FAIL rst_mem_after instret got %0d want 0", instret); end
    @(posedge clk); #1 rst = 1'b0; enable = 1'b0;
    m_ret = '0; m_cyc = '0; m_stl = '0;
  endtask

  task automatic test_random();
    logic [6:0] ops [6];
    logic en_after;
    ops[0] = OP_R; ops[1] = OP_I; ops[2] = OP_LD;
    ops[3] = OP_ST; ops[4] = OP_BR; ops[5] = OP_JAL;
    do_reset();
    add_idle(1);
    for (int k = 0; k < 40; k++) begin
      en_after = (k == 39) ? 1'b0 : rb();
      add_instr(ops[$urandom_range(0, 5)], $urandom_range(0, 6), $urandom_range(0, 6), en_after);
      if (!en_after && k != 39) add_idle($urandom_range(0, 2));
    end
    run_trace();
    foreach (done[i]) begin
      vecs++;
      if (o_out[i] !== done[i].exp) begin errs++; $display("FAIL random c%0d outputs got %h want %h", i, o_out[i], done[i].exp); end
      if (o_ret[i] !== e_ret[i]) begin errs++; $display("FAIL random c%0d instret got %0d want %0d", i, o_ret[i], e_ret[i]); end
      if (o_cyc[i] !== e_cyc[i] || o_stl[i] !== e_stl[i]) begin
        errs++; $display("FAIL random c%0d perf got %0d/%0d want %0d/%0d", i, o_cyc[i], o_stl[i], e_cyc[i], e_stl[i]);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; enable = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0; opcode = '0;
    m_ret = '0; m_cyc = '0; m_stl = '0;
    test_reset();
    test_r_type();
    test_ld_stall();
    test_st_br_jal();
    test_timeout();
    test_illegal_and_rst();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
